vend_sequencer: RTL and testbench
=================================

// Module: vend_sequencer
// PURPOSE
//   Controller that sequences the vending-machine datapath: accumulates coin credit,
//   arbitrates simultaneous coin, order and cancel events, fires the product-dispense strobe,
//   and drives the change/refund dispenser through a valid/ready handshake.
//   Sits between the coin/button front end (N, D, Q, O, E) and the product and change mechanisms.
// PARAMETERS
//   PRICE        65   item price in cents; multiple of 5, 5..MAX_CREDIT
//   MAX_CREDIT   100  credit ceiling in cents; multiple of 5, < 2**CREDIT_W
//   CREDIT_W     8    width of the credit register
//   VEND_CYCLES  4    cycles spent in VEND, >= 1
// PORTS
//   clk        in   1         system clock, rising edge
//   rst_n      in   1         asynchronous active-low reset
//   N          in   1         nickel strobe (5c), one-cycle pulse
//   D          in   1         dime strobe (10c), one-cycle pulse
//   Q          in   1         quarter strobe (25c), one-cycle pulse
//   O          in   1         order request, level sampled each cycle
//   E          in   1         escape/cancel request, level sampled each cycle
//   chg_ready  in   1         change dispenser accepts a coin
//   credit     out  CREDIT_W  current credit in cents
//   S          out  1         product-dispense strobe, one cycle
//   status     out  1         1 when state != IDLE
//   coin_rej   out  1         one-cycle pulse: a strobed coin was returned
//   chg_valid  out  1         change coin offered
//   chg_coin   out  2         01 nickel, 10 dime, 11 quarter, 00 when chg_valid=0
// BEHAVIOUR
//   Reset (async, any state): state=IDLE, credit=0, all outputs 0. Credit mid-vend is discarded, no refund.
//   States: IDLE, VEND, CHANGE. All outputs are registered.
//   IDLE, coins:
//   - Strobes are registered; credit updates on the edge after the strobe.
//   - Simultaneous strobes: accept one, priority Q > D > N. Each other coin raises coin_rej the next cycle.
//   - A coin that would push credit above MAX_CREDIT is rejected: coin_rej=1, credit unchanged.
//   IDLE, buttons (priority: E > O > coins; a coin arriving with an accepted E/O is rejected):
//   - E with credit>0 -> CHANGE (full refund). E with credit==0 is ignored.
//   - O with credit>=PRICE -> VEND; credit-=PRICE on the same edge. O with credit<PRICE is ignored.
//   VEND:
//   - S=1 on the first VEND cycle only.
//   - Stay exactly VEND_CYCLES cycles, then go to CHANGE if credit>0, else IDLE.
//   - O, E ignored. Coins rejected.
//   CHANGE:
//   - chg_valid=1 and chg_coin = largest coin <= credit (greedy 25/10/5).
//   - A coin transfers on a cycle with chg_valid & chg_ready; credit decrements on that edge and the
//     next coin is offered the following cycle.
//   - chg_coin is held stable while chg_valid & !chg_ready. No timeout.
//   - When credit reaches 0: chg_valid=0 the next cycle, state -> IDLE.
//   - O, E ignored. Coins rejected.
//   Arithmetic: credit is always a multiple of 5, never negative, never > MAX_CREDIT.
// TESTING
//   1. Q,D,Q,D,N pulses spaced 5 cycles (75c), then O -> credit 75->10, S one pulse,
//      status=1 for 4 cycles, then one dime on chg (chg_coin=10), back to IDLE with credit=0.
//   2. Credit 20, O -> no S, status stays 0, credit 20. Then E -> change sequence dime, dime; credit 0.
//   3. N,D,Q strobed in the same cycle from credit 0 -> credit 25, coin_rej=1 for one cycle.
//   4. Credit 90, Q -> coin_rej=1, credit stays 90. Then N -> credit 95.
//   5. Refund 40c with chg_ready held low 3 cycles -> chg_coin=11 held stable; then 25, 10, 5 transfer
//      on successive ready cycles.
//   6. Assert rst_n low mid-VEND and mid-CHANGE -> immediately credit=0, S=0, status=0, chg_valid=0;
//      after release, a fresh Q+D+Q+N (65) plus O vends with no change.

Source files
------------

// File: rtl/vend_sequencer.sv
// Vending-machine sequencer: coin credit accumulation, order/cancel arbitration,
// product-dispense strobe and greedy change payout over a valid/ready handshake.
module vend_sequencer #(
  parameter int unsigned PRICE       = 65,
  parameter int unsigned MAX_CREDIT  = 100,
  parameter int unsigned CREDIT_W    = 8,
  parameter int unsigned VEND_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                N,
  input  logic                D,
  input  logic                Q,
  input  logic                O,
  input  logic                E,
  input  logic                chg_ready,
  output logic [CREDIT_W-1:0] credit,
  output logic                S,
  output logic                status,
  output logic                coin_rej,
  output logic                chg_valid,
  output logic [1:0]          chg_coin
);

  localparam int unsigned SumW = CREDIT_W + 1;
  localparam int unsigned CntW = (VEND_CYCLES > 1) ? $clog2(VEND_CYCLES) : 1;

  localparam logic [CREDIT_W-1:0] PriceC   = CREDIT_W'(PRICE);
  localparam logic [SumW-1:0]     MaxC     = SumW'(MAX_CREDIT);
  localparam logic [CntW-1:0]     CntLastC = CntW'(VEND_CYCLES - 1);

  localparam logic [1:0] CoinNone = 2'b00;
  localparam logic [1:0] CoinN    = 2'b01;
  localparam logic [1:0] CoinD    = 2'b10;
  localparam logic [1:0] CoinQ    = 2'b11;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StVend   = 2'd1,
    StChange = 2'd2
  } state_t;

  // Value in cents of a coin code.
  function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] code);
    logic [CREDIT_W-1:0] v;
    case (code)
      CoinQ:   v = CREDIT_W'(25);
      CoinD:   v = CREDIT_W'(10);
      CoinN:   v = CREDIT_W'(5);
      default: v = '0;
    endcase
    return v;
  endfunction

  // Largest coin not exceeding the given amount (greedy 25/10/5).
  function automatic logic [1:0] greedy_coin(input logic [CREDIT_W-1:0] amt);
    logic [1:0] c;
    if (amt >= CREDIT_W'(25)) begin
      c = CoinQ;
    end else if (amt >= CREDIT_W'(10)) begin
      c = CoinD;
    end else if (amt >= CREDIT_W'(5)) begin
      c = CoinN;
    end else begin
      c = CoinNone;
    end
    return c;
  endfunction

  // Registered front-end strobes/buttons.
  logic r_n, r_d, r_q, r_o, r_e;

  // Architectural state and registered outputs.
  state_t              r_state;
  logic [CREDIT_W-1:0] r_credit;
  logic [CntW-1:0]     r_cnt;
  logic                r_s;
  logic                r_status;
  logic                r_coin_rej;
  logic                r_chg_valid;
  logic [1:0]          r_chg_coin;

  // Next-state values.
  state_t              w_state_d;
  logic [CREDIT_W-1:0] w_credit_d;
  logic [CntW-1:0]     w_cnt_d;
  logic                w_s_d;
  logic                w_rej_d;
  logic                w_chg_valid_d;
  logic [1:0]          w_chg_coin_d;

  // Coin arbitration helpers.
  logic                w_any_coin;
  logic                w_multi_coin;
  logic [1:0]          w_sel_coin;
  logic [SumW-1:0]     w_sum;
  logic [CREDIT_W-1:0] w_chg_left;

  // Sample the front-end inputs so all decisions use one clean cycle of data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n <= 1'b0;
      r_d <= 1'b0;
      r_q <= 1'b0;
      r_o <= 1'b0;
      r_e <= 1'b0;
    end else begin
      r_n <= N;
      r_d <= D;
      r_q <= Q;
      r_o <= O;
      r_e <= E;
    end
  end

  // Coin priority Q > D > N, candidate credit and remaining change after a payout.
  always_comb begin
    w_any_coin   = r_n | r_d | r_q;
    w_multi_coin = (r_q & (r_d | r_n)) | (r_d & r_n);
    if (r_q) begin
      w_sel_coin = CoinQ;
    end else if (r_d) begin
      w_sel_coin = CoinD;
    end else if (r_n) begin
      w_sel_coin = CoinN;
    end else begin
      w_sel_coin = CoinNone;
    end
    w_sum      = {1'b0, r_credit} + {1'b0, coin_value(w_sel_coin)};
    w_chg_left = r_credit - coin_value(r_chg_coin);
  end

  // Next-state and next-output decode for the sequencer.
  always_comb begin
    w_state_d     = r_state;
    w_credit_d    = r_credit;
    w_cnt_d       = r_cnt;
    w_s_d         = 1'b0;
    w_rej_d       = 1'b0;
    w_chg_valid_d = r_chg_valid;
    w_chg_coin_d  = r_chg_coin;

    case (r_state)
      StIdle: begin
        if (r_e && (r_credit != '0)) begin
          // Full refund; any coin seen alongside the cancel goes back.
          w_state_d     = StChange;
          w_chg_valid_d = 1'b1;
          w_chg_coin_d  = greedy_coin(r_credit);
          w_rej_d       = w_any_coin;
        end else if (r_o && (r_credit >= PriceC)) begin
          w_state_d  = StVend;
          w_credit_d = r_credit - PriceC;
          w_cnt_d    = '0;
          w_s_d      = 1'b1;
          w_rej_d    = w_any_coin;
        end else if (w_any_coin) begin
          // Losing coins are returned; the winner is returned too if it would overflow.
          if (w_sum > MaxC) begin
            w_rej_d = 1'b1;
          end else begin
            w_credit_d = w_sum[CREDIT_W-1:0];
            w_rej_d    = w_multi_coin;
          end
        end
      end

      StVend: begin
        w_rej_d = w_any_coin;
        if (r_cnt == CntLastC) begin
          if (r_credit != '0) begin
            w_state_d     = StChange;
            w_chg_valid_d = 1'b1;
            w_chg_coin_d  = greedy_coin(r_credit);
          end else begin
            w_state_d = StIdle;
          end
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end

      StChange: begin
        w_rej_d = w_any_coin;
        if (!r_chg_valid) begin
          w_state_d = StIdle;
        end else if (chg_ready) begin
          w_credit_d = w_chg_left;
          if (w_chg_left == '0) begin
            w_state_d     = StIdle;
            w_chg_valid_d = 1'b0;
            w_chg_coin_d  = CoinNone;
          end else begin
            w_chg_coin_d = greedy_coin(w_chg_left);
          end
        end
      end

      default: begin
        w_state_d     = StIdle;
        w_chg_valid_d = 1'b0;
        w_chg_coin_d  = CoinNone;
      end
    endcase
  end

  // Sequencer state register; every output is registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_credit    <= '0;
      r_cnt       <= '0;
      r_s         <= 1'b0;
      r_status    <= 1'b0;
      r_coin_rej  <= 1'b0;
      r_chg_valid <= 1'b0;
      r_chg_coin  <= CoinNone;
    end else begin
      r_state     <= w_state_d;
      r_credit    <= w_credit_d;
      r_cnt       <= w_cnt_d;
      r_s         <= w_s_d;
      r_status    <= (w_state_d != StIdle);
      r_coin_rej  <= w_rej_d;
      r_chg_valid <= w_chg_valid_d;
      r_chg_coin  <= w_chg_coin_d;
    end
  end

  assign credit    = r_credit;
  assign S         = r_s;
  assign status    = r_status;
  assign coin_rej  = r_coin_rej;
  assign chg_valid = r_chg_valid;
  assign chg_coin  = r_chg_coin;

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed scoreboard bench for vend_sequencer.
module tb_vend_sequencer;

  localparam int SigCredit = 0;
  localparam int SigS      = 1;
  localparam int SigStatus = 2;
  localparam int SigRej    = 3;
  localparam int SigValid  = 4;
  localparam int SigCoin   = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       N = 1'b0, D = 1'b0, Q = 1'b0, O = 1'b0, E = 1'b0;
  logic       chg_ready = 1'b0;
  logic [7:0] credit;
  logic       S, status, coin_rej, chg_valid;
  logic [1:0] chg_coin;

  typedef struct {
    string       tag;
    int          sig;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   chg_q[$];
  int   checks = 0;
  int   failures = 0;

  vend_sequencer #(
    .PRICE      (65),
    .MAX_CREDIT (100),
    .CREDIT_W   (8),
    .VEND_CYCLES(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .N        (N),
    .D        (D),
    .Q        (Q),
    .O        (O),
    .E        (E),
    .chg_ready(chg_ready),
    .credit   (credit),
    .S        (S),
    .status   (status),
    .coin_rej (coin_rej),
    .chg_valid(chg_valid),
    .chg_coin (chg_coin)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] observe(input int sig);
    case (sig)
      SigCredit: return 32'(credit);
      SigS:      return 32'(S);
      SigStatus: return 32'(status);
      SigRej:    return 32'(coin_rej);
      SigValid:  return 32'(chg_valid);
      default:   return 32'(chg_coin);
    endcase
  endfunction

  task automatic push_exp(input string tag, input int sig, input int val);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.val = 32'(val);
    sb_q.push_back(e);
  endtask

  // Pop every pending expectation and compare it with the current outputs.
  task automatic chk();
    exp_t        e;
    logic [31:0] obs;
    while (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      obs = observe(e.sig);
      checks++;
      assert (obs === e.val) else begin
        failures++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Strobe coins for one cycle; credit reflects them one cycle after return.
  task automatic pulse(input logic n, input logic d, input logic q);
    N = n; D = d; Q = q;
    tick(1);
    N = 1'b0; D = 1'b0; Q = 1'b0;
  endtask

  task automatic coin_step(input string tag, input logic n, input logic d, input logic q,
                           input int exp_credit, input int exp_rej);
    pulse(n, d, q);
    push_exp({tag, "_credit"}, SigCredit, exp_credit);
    push_exp({tag, "_rej"}, SigRej, exp_rej);
    tick(1);
    chk();
  endtask

  // Hold a button for one cycle and advance to the cycle where its effect shows.
  task automatic press(input logic o, input logic e);
    O = o; E = e;
    tick(1);
    O = 1'b0; E = 1'b0;
    tick(1);
  endtask

  // Accept change coins back-to-back against the expected coin queue.
  task automatic drain(input string tag);
    int waitc = 0;
    int c;
    while (chg_valid !== 1'b1 && waitc < 20) begin
      tick(1);
      waitc++;
    end
    chg_ready = 1'b1;
    while (chg_q.size() > 0) begin
      c = chg_q.pop_front();
      push_exp({tag, "_valid"}, SigValid, 1);
      push_exp({tag, "_coin"}, SigCoin, c);
      chk();
      tick(1);
    end
    chg_ready = 1'b0;
    push_exp({tag, "_done_valid"}, SigValid, 0);
    push_exp({tag, "_done_coin"}, SigCoin, 0);
    push_exp({tag, "_done_credit"}, SigCredit, 0);
    push_exp({tag, "_done_status"}, SigStatus, 0);
    chk();
  endtask

  task automatic reset_pulse(input string tag);
    rst_n = 1'b0;
    #1;
    push_exp({tag, "_credit"}, SigCredit, 0);
    push_exp({tag, "_s"}, SigS, 0);
    push_exp({tag, "_status"}, SigStatus, 0);
    push_exp({tag, "_valid"}, SigValid, 0);
    push_exp({tag, "_coin"}, SigCoin, 0);
    push_exp({tag, "_rej"}, SigRej, 0);
    chk();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(1);
  endtask

  initial begin
    // Reset state
    tick(2);
    push_exp("rst_credit", SigCredit, 0);
    push_exp("rst_s", SigS, 0);
    push_exp("rst_status", SigStatus, 0);
    push_exp("rst_rej", SigRej, 0);
    push_exp("rst_valid", SigValid, 0);
    push_exp("rst_coin", SigCoin, 0);
    chk();
    rst_n = 1'b1;
    tick(1);

    // 1: 75c then order -> 10c change as one dime
    coin_step("t1_q1", 1'b0, 1'b0, 1'b1, 25, 0); tick(3);
    coin_step("t1_d1", 1'b0, 1'b1, 1'b0, 35, 0); tick(3);
    coin_step("t1_q2", 1'b0, 1'b0, 1'b1, 60, 0); tick(3);
    coin_step("t1_d2", 1'b0, 1'b1, 1'b0, 70, 0); tick(3);
    coin_step("t1_n1", 1'b1, 1'b0, 1'b0, 75, 0); tick(3);
    press(1'b1, 1'b0);
    chg_q.push_back(2);
    push_exp("t1_vend_s", SigS, 1);
    push_exp("t1_vend_status", SigStatus, 1);
    push_exp("t1_vend_credit", SigCredit, 10);
    chk();
    tick(1);
    push_exp("t1_s_once", SigS, 0);
    push_exp("t1_status_vend2", SigStatus, 1);
    chk();
    tick(2);
    push_exp("t1_status_vend4", SigStatus, 1);
    push_exp("t1_novalid_vend4", SigValid, 0);
    chk();
    tick(1);
    push_exp("t1_chg_status", SigStatus, 1);
    chk();
    drain("t1_chg");

    // 2: order below price ignored, then cancel refunds two dimes
    coin_step("t2_d1", 1'b0, 1'b1, 1'b0, 10, 0);
    coin_step("t2_d2", 1'b0, 1'b1, 1'b0, 20, 0);
    press(1'b1, 1'b0);
    push_exp("t2_no_s", SigS, 0);
    push_exp("t2_no_status", SigStatus, 0);
    push_exp("t2_credit", SigCredit, 20);
    chk();
    tick(1);
    push_exp("t2_no_s_late", SigS, 0);
    chk();
    press(1'b0, 1'b1);
    chg_q.push_back(2);
    chg_q.push_back(2);
    push_exp("t2_refund_status", SigStatus, 1);
    chk();
    drain("t2_chg");

    // 3: simultaneous N,D,Q -> quarter accepted, others rejected for one cycle
    coin_step("t3_multi", 1'b1, 1'b1, 1'b1, 25, 1);
    tick(1);
    push_exp("t3_rej_clear", SigRej, 0);
    push_exp("t3_credit_hold", SigCredit, 25);
    chk();

    // 4: ceiling rejection at 90, nickel to 95, then refund 95
    coin_step("t4_q", 1'b0, 1'b0, 1'b1, 50, 0);
    coin_step("t4_q2", 1'b0, 1'b0, 1'b1, 75, 0);
    coin_step("t4_d", 1'b0, 1'b1, 1'b0, 85, 0);
    coin_step("t4_n", 1'b1, 1'b0, 1'b0, 90, 0);
    coin_step("t4_q_over", 1'b0, 1'b0, 1'b1, 90, 1);
    coin_step("t4_n_95", 1'b1, 1'b0, 1'b0, 95, 0);
    press(1'b0, 1'b1);
    chg_q.push_back(3); chg_q.push_back(3); chg_q.push_back(3);
    chg_q.push_back(2); chg_q.push_back(2);
    drain("t4_chg");

    // 5: refund 40 with dispenser stalled, then 25/10/5
    coin_step("t5_q", 1'b0, 1'b0, 1'b1, 25, 0);
    coin_step("t5_d", 1'b0, 1'b1, 1'b0, 35, 0);
    coin_step("t5_n", 1'b1, 1'b0, 1'b0, 40, 0);
    press(1'b0, 1'b1);
    chg_q.push_back(3); chg_q.push_back(2); chg_q.push_back(1);
    for (int i = 0; i < 3; i++) begin
      push_exp("t5_stall_valid", SigValid, 1);
      push_exp("t5_stall_coin", SigCoin, 3);
      push_exp("t5_stall_credit", SigCredit, 40);
      chk();
      tick(1);
    end
    drain("t5_chg");

    // 6: reset mid-VEND and mid-CHANGE, then clean exact-price vend
    coin_step("t6_q", 1'b0, 1'b0, 1'b1, 25, 0);
    coin_step("t6_q2", 1'b0, 1'b0, 1'b1, 50, 0);
    coin_step("t6_d", 1'b0, 1'b1, 1'b0, 60, 0);
    coin_step("t6_d2", 1'b0, 1'b1, 1'b0, 70, 0);
    press(1'b1, 1'b0);
    push_exp("t6_vend_s", SigS, 1);
    push_exp("t6_vend_credit", SigCredit, 5);
    chk();
    tick(1);
    reset_pulse("t6_rst_vend");
    coin_step("t6b_q", 1'b0, 1'b0, 1'b1, 25, 0);
    coin_step("t6b_d", 1'b0, 1'b1, 1'b0, 35, 0);
    coin_step("t6b_n", 1'b1, 1'b0, 1'b0, 40, 0);
    press(1'b0, 1'b1);
    push_exp("t6b_chg_valid", SigValid, 1);
    push_exp("t6b_chg_coin", SigCoin, 3);
    chk();
    tick(1);
    reset_pulse("t6_rst_chg");
    coin_step("t6c_q", 1'b0, 1'b0, 1'b1, 25, 0);
    coin_step("t6c_d", 1'b0, 1'b1, 1'b0, 35, 0);
    coin_step("t6c_q2", 1'b0, 1'b0, 1'b1, 60, 0);
    coin_step("t6c_n", 1'b1, 1'b0, 1'b0, 65, 0);
    press(1'b1, 1'b0);
    push_exp("t6c_s", SigS, 1);
    push_exp("t6c_credit", SigCredit, 0);
    push_exp("t6c_status", SigStatus, 1);
    chk();
    tick(1);
    push_exp("t6c_s_off", SigS, 0);
    chk();
    tick(3);
    push_exp("t6c_idle_status", SigStatus, 0);
    push_exp("t6c_idle_valid", SigValid, 0);
    push_exp("t6c_idle_credit", SigCredit, 0);
    chk();
    tick(2);
    push_exp("t6c_no_change", SigValid, 0);
    chk();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
